// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the data-memory responder.
// Holds FSM state encoding, access-type encoding and default sizes.
package data_mem_pkg;

  localparam int DEF_DEPTH_BYTES = 128;
  localparam int DEF_WAIT_CYCLES = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    ACC_READ,
    ACC_WRITE,
    ACC_BAD
  } acc_t;

endpackage

// File: rtl/data_mem_if.sv
// Core <-> data-memory bus: active-low strobes, address, store data
// (master drives) and load data, ready pulse, error flag (slave drives).
interface data_mem_if;

  logic        nRD;
  logic        nWR;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] Dataout;
  logic        ready;
  logic        err;

  modport master (
    output nRD, nWR, address, writeData,
    input  Dataout, ready, err
  );

  modport slave (
    input  nRD, nWR, address, writeData,
    output Dataout, ready, err
  );

endinterface

// File: rtl/dmem_byte_array.sv
// Byte storage with one big-endian 32-bit word port.
// Ports: clk, we (sync write), word (word index), wdata, rdata (comb).
module dmem_byte_array #(
  parameter int DEPTH_BYTES = 128,
  localparam int AW = $clog2(DEPTH_BYTES),
  localparam int WW = AW - 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [WW-1:0] word,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [7:0] mem [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{word, 2'd0}] <= wdata[31:24];
      mem[{word, 2'd1}] <= wdata[23:16];
      mem[{word, 2'd2}] <= wdata[15:8];
      mem[{word, 2'd3}] <= wdata[7:0];
    end
  end

  assign rdata = {
    mem[{word, 2'd0}],
    mem[{word, 2'd1}],
    mem[{word, 2'd2}],
    mem[{word, 2'd3}]
  };

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts strobed accesses, waits WAIT_CYCLES,
// then pulses ready. Ports: clk, RST (async low), bus (slave).
// Option: DATA_MEM_ALIGN_CHECK_EN flags misaligned accesses as errors.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = DEF_DEPTH_BYTES,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input logic       clk,
  input logic       RST,
  data_mem_if.slave bus
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int LD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0] CNT_LOAD = 4'(LD);

  state_t        state_q, state_d;
  acc_t          acc_q, acc_in, acc_cur;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:2] addr_q, addr_cur;
  logic [31:0]   wdata_q, wdata_cur;
  logic [31:0]   rdata, dout_q;
  logic          ready_q, err_q;
  logic          req, idle, resp_go, we;
  logic          unused_addr;

  assign unused_addr = ^{bus.address[31:AW], bus.address[1:0]};

  assign req  = !bus.nRD || !bus.nWR;
  assign idle = (state_q == ST_IDLE);

  always_comb begin
    acc_in = ACC_READ;
    unique case (1'b1)
      (!bus.nRD && !bus.nWR): acc_in = ACC_BAD;
      (bus.nRD && !bus.nWR):  acc_in = ACC_WRITE;
      default:                acc_in = ACC_READ;
    endcase
`ifdef DATA_MEM_ALIGN_CHECK_EN
    if (bus.address[1:0] != 2'b00) acc_in = ACC_BAD;
`endif
  end

  // With zero wait cycles the response happens on the accept edge,
  // before anything is latched, so use the live bus in IDLE.
  assign acc_cur   = idle ? acc_in : acc_q;
  assign addr_cur  = idle ? bus.address[AW-1:2] : addr_q;
  assign wdata_cur = idle ? bus.writeData : wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    resp_go = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            resp_go = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          resp_go = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_DONE;
      ST_DONE: begin
        if (bus.nRD && bus.nWR) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign we = resp_go && (acc_cur == ACC_WRITE);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      acc_q   <= ACC_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= resp_go;
      err_q   <= resp_go && (acc_cur == ACC_BAD);
      if (idle && req) begin
        acc_q   <= acc_in;
        addr_q  <= bus.address[AW-1:2];
        wdata_q <= bus.writeData;
      end
      if (resp_go && acc_cur != ACC_WRITE) begin
        dout_q <= (acc_cur == ACC_READ) ? rdata : '0;
      end
    end
  end

  dmem_byte_array #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_arr (
    .clk  (clk),
    .we   (we),
    .word (addr_cur),
    .wdata(wdata_cur),
    .rdata(rdata)
  );

  assign bus.Dataout = dout_q;
  assign bus.ready   = ready_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (WAIT 1 and 3), byte
// model, directed scenarios plus randomized accesses.
module tb_data_mem_responder;
  import data_mem_pkg::*;

  logic clk = 1'b0;
  logic rst1, rst3;

  data_mem_if bus1 ();
  data_mem_if bus3 ();

  data_mem_responder #(
    .DEPTH_BYTES(128),
    .WAIT_CYCLES(1)
  ) u_w1 (
    .clk(clk),
    .RST(rst1),
    .bus(bus1)
  );

  data_mem_responder #(
    .DEPTH_BYTES(128),
    .WAIT_CYCLES(3)
  ) u_w3 (
    .clk(clk),
    .RST(rst3),
    .bus(bus3)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  mm [2][128];
  logic [31:0] last [2];
  int          wc [2] = '{1, 3};

  function automatic logic rdy(input int s);
    return (s == 0) ? bus1.ready : bus3.ready;
  endfunction

  function automatic logic erf(input int s);
    return (s == 0) ? bus1.err : bus3.err;
  endfunction

  function automatic logic [31:0] dof(input int s);
    return (s == 0) ? bus1.Dataout : bus3.Dataout;
  endfunction

  task automatic drive(input int s, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (s == 0) begin
      bus1.nRD = !rd; bus1.nWR = !wr;
      bus1.address = a; bus1.writeData = d;
    end else begin
      bus3.nRD = !rd; bus3.nWR = !wr;
      bus3.address = a; bus3.writeData = d;
    end
  endtask

  // Expected outcome of one access from the byte-level rules.
  task automatic model_step(input int s, input bit rd, input bit wr,
                            input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] xd, output logic xe);
    int b;
    bit bad_acc;
    b = int'(a % 128) / 4 * 4;
    bad_acc = rd && wr;
`ifdef DATA_MEM_ALIGN_CHECK_EN
    if (a % 4 != 0) bad_acc = 1'b1;
`endif
    xe = 1'b0;
    if (bad_acc) begin
      xd = 32'd0;
      xe = 1'b1;
    end else if (wr) begin
      for (int i = 0; i < 4; i++) mm[s][b + i] = d[31 - 8 * i -: 8];
      xd = last[s];
    end else begin
      xd = {mm[s][b], mm[s][b + 1], mm[s][b + 2], mm[s][b + 3]};
    end
    last[s] = xd;
  endtask

  // Drives one access (called at a negedge, returns at a negedge).
  // lat = edges after accept until ready is visible; -1 on timeout.
  task automatic access(input int s, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input int hold,
                        output logic [31:0] dout, output logic e,
                        output int lat, output logic rdy_after,
                        output int seen);
    lat = -1; dout = 'x; e = 1'bx; seen = -1;
    drive(s, rd, wr, a, d);
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) drive(s, rd, wr, $urandom, $urandom);
      if (rdy(s)) begin
        lat = k; dout = dof(s); e = erf(s); seen = cyc;
        break;
      end
      @(posedge clk);
    end
    if (hold == 0) begin
      drive(s, 0, 0, $urandom, $urandom);
      @(negedge clk);
      rdy_after = rdy(s);
      @(negedge clk);
    end else begin
      @(negedge clk);
      rdy_after = rdy(s);
      repeat (hold) @(negedge clk);
      drive(s, 0, 0, $urandom, $urandom);
      repeat (2) @(negedge clk);
    end
  endtask

  logic [31:0] got, xd;
  logic        ge, xe, ra;
  int          lat, sc;

  task automatic test_reset;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    rst1 = 1'b0; rst3 = 1'b0;
    last[0] = 0; last[1] = 0;
    repeat (3) @(negedge clk);
    total++;
    if (bus1.ready !== 1'b0 || bus3.ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_ready got=%b/%b want=0", bus1.ready, bus3.ready);
    end
    total++;
    if (bus1.err !== 1'b0 || bus3.err !== 1'b0) begin
      bad++;
      $display("FAIL rst_err got=%b/%b want=0", bus1.err, bus3.err);
    end
    total++;
    if (bus1.Dataout !== 0 || bus3.Dataout !== 0) begin
      bad++;
      $display("FAIL rst_dout got=%h/%h want=0", bus1.Dataout, bus3.Dataout);
    end
    total++;
    if (u_w1.state_q !== ST_IDLE) begin
      bad++;
      $display("FAIL rst_state got=%0d want=%0d", u_w1.state_q, ST_IDLE);
    end
    rst1 = 1'b1; rst3 = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_read;
    access(0, 0, 1, 32'h10, 32'h12345678, 0, got, ge, lat, ra, sc);
    model_step(0, 0, 1, 32'h10, 32'h12345678, xd, xe);
    total++;
    if (lat !== wc[0]) begin
      bad++; $display("FAIL wr_lat got=%0d want=%0d", lat, wc[0]);
    end
    total++;
    if (ge !== xe) begin
      bad++; $display("FAIL wr_err got=%b want=%b", ge, xe);
    end
    total++;
    if (ra !== 1'b0) begin
      bad++; $display("FAIL wr_pulse got=%b want=0", ra);
    end
    access(0, 1, 0, 32'h10, 32'h0, 0, got, ge, lat, ra, sc);
    model_step(0, 1, 0, 32'h10, 32'h0, xd, xe);
    total++;
    if (got !== xd || ge !== xe) begin
      bad++;
      $display("FAIL rd_10 got=%h/%b want=%h/%b", got, ge, xd, xe);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (u_w1.u_arr.mem[16 + i] !== mm[0][16 + i]) begin
        bad++;
        $display("FAIL byte_%0d got=%h want=%h", 16 + i,
                 u_w1.u_arr.mem[16 + i], mm[0][16 + i]);
      end
    end
  endtask

  task automatic test_wrap;
    access(0, 0, 1, 32'h84, 32'hCAFEF00D, 0, got, ge, lat, ra, sc);
    model_step(0, 0, 1, 32'h84, 32'hCAFEF00D, xd, xe);
    access(0, 1, 0, 32'h04, 32'h0, 0, got, ge, lat, ra, sc);
    model_step(0, 1, 0, 32'h04, 32'h0, xd, xe);
    total++;
    if (got !== xd || ge !== xe) begin
      bad++;
      $display("FAIL wrap got=%h/%b want=%h/%b", got, ge, xd, xe);
    end
  endtask

  task automatic test_both_low;
    access(0, 1, 0, 32'h10, 32'h0, 0, got, ge, lat, ra, sc);
    model_step(0, 1, 0, 32'h10, 32'h0, xd, xe);
    access(0, 1, 1, 32'h10, 32'hDEADBEEF, 0, got, ge, lat, ra, sc);
    model_step(0, 1, 1, 32'h10, 32'hDEADBEEF, xd, xe);
    total++;
    if (got !== xd || ge !== xe || lat !== wc[0]) begin
      bad++;
      $display("FAIL both_low got=%h/%b/%0d want=%h/%b/%0d",
               got, ge, lat, xd, xe, wc[0]);
    end
    access(0, 1, 0, 32'h10, 32'h0, 0, got, ge, lat, ra, sc);
    model_step(0, 1, 0, 32'h10, 32'h0, xd, xe);
    total++;
    if (got !== xd || ge !== xe) begin
      bad++;
      $display("FAIL after_bad got=%h/%b want=%h/%b", got, ge, xd, xe);
    end
  endtask

  task automatic test_held;
    int pulses;
    pulses = 0;
    drive(0, 1, 0, 32'h10, 32'h0);
    repeat (10) begin
      @(negedge clk);
      if (bus1.ready) pulses++;
    end
    model_step(0, 1, 0, 32'h10, 32'h0, xd, xe);
    total++;
    if (pulses !== 1) begin
      bad++; $display("FAIL held_pulses got=%0d want=1", pulses);
    end
    total++;
    if (bus1.Dataout !== xd) begin
      bad++; $display("FAIL held_dout got=%h want=%h", bus1.Dataout, xd);
    end
    drive(0, 0, 0, 32'h10, 32'h0);
    @(negedge clk);
    drive(0, 1, 0, 32'h10, 32'h0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus1.ready) pulses++;
    end
    model_step(0, 1, 0, 32'h10, 32'h0, xd, xe);
    total++;
    if (pulses !== 1) begin
      bad++; $display("FAIL reassert_pulses got=%0d want=1", pulses);
    end
    drive(0, 0, 0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_misaligned;
    access(0, 1, 0, 32'h11, 32'h0, 0, got, ge, lat, ra, sc);
    model_step(0, 1, 0, 32'h11, 32'h0, xd, xe);
    total++;
    if (got !== xd || ge !== xe) begin
      bad++;
      $display("FAIL misalign got=%h/%b want=%h/%b", got, ge, xd, xe);
    end
  endtask

  task automatic test_back_to_back;
    int prev;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      access(0, 0, 1, 32'h40 + 4 * i, $urandom, 0, got, ge, lat, ra, sc);
      if (prev >= 0) begin
        total++;
        if (sc - prev !== wc[0] + 3) begin
          bad++;
          $display("FAIL b2b_gap got=%0d want=%0d", sc - prev, wc[0] + 3);
        end
      end
      prev = sc;
    end
    for (int i = 0; i < 4; i++) begin
      model_step(0, 0, 1, 32'h40 + 4 * i, 32'h0, xd, xe);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, d;
    bit rd, wr;
    int r, h;
    for (int w = 0; w < 32; w++) begin
      d = $urandom;
      access(0, 0, 1, 4 * w, d, 0, got, ge, lat, ra, sc);
      model_step(0, 0, 1, 4 * w, d, xd, xe);
      total++;
      if (ge !== xe || lat !== wc[0]) begin
        bad++;
        $display("FAIL fill_%0d got=%b/%0d want=%b/%0d",
                 w, ge, lat, xe, wc[0]);
      end
    end
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      rd = (r <= 5);
      wr = (r == 0) || (r > 5);
      a = $urandom_range(0, 255);
      d = $urandom;
      h = $urandom_range(0, 3);
      access(0, rd, wr, a, d, h, got, ge, lat, ra, sc);
      model_step(0, rd, wr, a, d, xd, xe);
      total++;
      if (got !== xd || ge !== xe || lat !== wc[0] || ra !== 1'b0) begin
        bad++;
        $display("FAIL rand_%0d a=%h rd=%b wr=%b got=%h/%b/%0d/%b want=%h/%b/%0d/0",
                 n, a, rd, wr, got, ge, lat, ra, xd, xe, wc[0]);
      end
    end
  endtask

  task automatic test_reset_mid;
    access(1, 0, 1, 32'h10, 32'h12345678, 0, got, ge, lat, ra, sc);
    model_step(1, 0, 1, 32'h10, 32'h12345678, xd, xe);
    access(1, 1, 0, 32'h10, 32'h0, 0, got, ge, lat, ra, sc);
    model_step(1, 1, 0, 32'h10, 32'h0, xd, xe);
    total++;
    if (got !== xd || lat !== wc[1]) begin
      bad++;
      $display("FAIL w3_rd got=%h/%0d want=%h/%0d", got, lat, xd, wc[1]);
    end
    drive(1, 0, 1, 32'h10, 32'hFFFFFFFF);
    @(posedge clk);
    @(posedge clk);
    #1 rst3 = 1'b0;
    last[1] = 0;
    #1;
    total++;
    if (bus3.ready !== 1'b0 || bus3.Dataout !== 0) begin
      bad++;
      $display("FAIL abort_out got=%b/%h want=0/0", bus3.ready, bus3.Dataout);
    end
    total++;
    if (u_w3.state_q !== ST_IDLE) begin
      bad++;
      $display("FAIL abort_state got=%0d want=%0d", u_w3.state_q, ST_IDLE);
    end
    drive(1, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    rst3 = 1'b1;
    repeat (2) @(negedge clk);
    access(1, 1, 0, 32'h10, 32'h0, 0, got, ge, lat, ra, sc);
    model_step(1, 1, 0, 32'h10, 32'h0, xd, xe);
    total++;
    if (got !== xd || ge !== xe || lat !== wc[1]) begin
      bad++;
      $display("FAIL abort_rd got=%h/%b/%0d want=%h/%b/%0d",
               got, ge, lat, xd, xe, wc[1]);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_both_low();
    test_held();
    test_misaligned();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
